// File: rtl/score_digit_addr.sv
// Four-digit score display: sequential double-dabble BCD conversion with atomic commit,
// plus glyph ROM address/digit generation for a strip of four windows on a VGA raster.
module score_digit_addr #(
    parameter int X0      = 160,
    parameter int Y0      = 180,
    parameter int DIGIT_W = 80,
    parameter int DIGIT_H = 120
) (
    input  logic        clk_25m,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic        score_load,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    output logic [16:0] addr,
    output logic [3:0]  num,
    output logic        digit_en,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [9:0]  COL3      = 10'(X0);
    localparam logic [9:0]  COL2      = 10'(X0 + DIGIT_W);
    localparam logic [9:0]  COL1      = 10'(X0 + 2 * DIGIT_W);
    localparam logic [9:0]  COL0      = 10'(X0 + 3 * DIGIT_W);
    localparam logic [9:0]  COL_END   = 10'(X0 + 4 * DIGIT_W);
    localparam logic [9:0]  ROW_TOP   = 10'(Y0);
    localparam logic [9:0]  ROW_END   = 10'(Y0 + DIGIT_H);
    localparam logic [16:0] ROW_STEP  = 17'(DIGIT_W);
    localparam logic [13:0] SCORE_MAX = 14'd9999;
    localparam logic [3:0]  LAST_BIT  = 4'd13;

    // Conversion state
    state_t           state_q, state_d;
    logic [13:0]      bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             pend_q, pend_d;
    logic [13:0]      pend_val_q, pend_val_d;
    logic [3:0][3:0]  digits_q, digits_d;

    // Display pipeline state
    logic [16:0]      row_base_q, row_base_d;
    logic [9:0]       v_prev_q, v_prev_d;
    logic [16:0]      addr_q, addr_d;
    logic [3:0]       num_q, num_d;
    logic             en1_q, en1_d;
    logic             digit_en_q, digit_en_d;

    // Combinational helpers
    logic [13:0]      load_val;
    logic [15:0]      bcd_adj;
    logic             in_rows;
    logic             win_hit;
    logic [9:0]       col_off;
    logic [3:0]       sel_digit;
    logic             sel_blank;
    logic             blank3, blank2, blank1;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        digits_d   = digits_q;

        load_val = (score > SCORE_MAX) ? SCORE_MAX : score;

        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (score_load) begin
                    state_d   = CONV;
                    bin_d     = load_val;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                end
            end

            CONV: begin
                if (score_load) begin
                    pend_d     = 1'b1;
                    pend_val_d = load_val;
                end
                bcd_d     = {bcd_adj[14:0], bin_q[13]};
                bin_d     = {bin_q[12:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = COMMIT;
                end
            end

            COMMIT: begin
                digits_d = bcd_q;
                // A load arriving now is newer than anything already pending.
                if (score_load || pend_q) begin
                    state_d   = CONV;
                    bin_d     = score_load ? load_val : pend_val_q;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    pend_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rows = (v_cnt >= ROW_TOP) && (v_cnt < ROW_END);

        // Row base tracks (v_cnt - Y0) * DIGIT_W by stepping once per new raster line.
        if (v_cnt == ROW_TOP) begin
            row_base_d = '0;
        end else if (v_cnt != v_prev_q) begin
            row_base_d = row_base_q + ROW_STEP;
        end else begin
            row_base_d = row_base_q;
        end
        v_prev_d = v_cnt;

        blank3 = (digits_q[3] == 4'd0);
        blank2 = blank3 && (digits_q[2] == 4'd0);
        blank1 = blank2 && (digits_q[1] == 4'd0);

        win_hit   = 1'b1;
        col_off   = '0;
        sel_digit = '0;
        sel_blank = 1'b0;
        if (h_cnt >= COL3 && h_cnt < COL2) begin
            col_off   = h_cnt - COL3;
            sel_digit = digits_q[3];
            sel_blank = blank3;
        end else if (h_cnt >= COL2 && h_cnt < COL1) begin
            col_off   = h_cnt - COL2;
            sel_digit = digits_q[2];
            sel_blank = blank2;
        end else if (h_cnt >= COL1 && h_cnt < COL0) begin
            col_off   = h_cnt - COL1;
            sel_digit = digits_q[1];
            sel_blank = blank1;
        end else if (h_cnt >= COL0 && h_cnt < COL_END) begin
            col_off   = h_cnt - COL0;
            sel_digit = digits_q[0];
        end else begin
            win_hit = 1'b0;
        end

        if (in_rows && win_hit) begin
            addr_d = row_base_d + 17'(col_off);
            num_d  = sel_digit;
            en1_d  = ~sel_blank;
        end else begin
            addr_d = '0;
            num_d  = '0;
            en1_d  = 1'b0;
        end
        digit_en_d = en1_q;
    end

    // NOTE: reset is synchronous (sampled on the clock edge) and all state updates use non-blocking assignment.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            digits_q   <= '0;
            row_base_q <= '0;
            v_prev_q   <= '0;
            addr_q     <= '0;
            num_q      <= '0;
            en1_q      <= 1'b0;
            digit_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            digits_q   <= digits_d;
            row_base_q <= row_base_d;
            v_prev_q   <= v_prev_d;
            addr_q     <= addr_d;
            num_q      <= num_d;
            en1_q      <= en1_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign addr     = addr_q;
    assign num      = num_q;
    assign digit_en = digit_en_q;
    assign busy     = (state_q == CONV);

endmodule

// File: tb/tb_score_digit_addr.sv
// Scoreboard bench for score_digit_addr: a driver queues expected pixel/address results and
// expected committed digits; two monitors pop and compare as the DUT produces them.
module tb_score_digit_addr;

    localparam int X0 = 160;
    localparam int Y0 = 180;
    localparam int W  = 80;
    localparam int H  = 120;

    typedef struct packed {
        logic [16:0] addr;
        logic [3:0]  num;
        logic        en;
        logic        rst;
    } exp_t;

    logic        clk_25m = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic        score_load;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [16:0] addr;
    logic [3:0]  num;
    logic        digit_en;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_dig = '0;
    exp_t        scan_q[$];
    logic [15:0] conv_q[$];

    score_digit_addr #(.X0(X0), .Y0(Y0), .DIGIT_W(W), .DIGIT_H(H)) dut (
        .clk_25m    (clk_25m),
        .rst        (rst),
        .score      (score),
        .score_load (score_load),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .addr       (addr),
        .num        (num),
        .digit_en   (digit_en),
        .busy       (busy)
    );

    always #20 clk_25m = ~clk_25m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int h, input int v, input bit r);
        exp_t e;
        int   k;
        e = '0;
        if (r) begin
            e.rst = 1'b1;
            return e;
        end
        if (v >= Y0 && v < Y0 + H && h >= X0 && h < X0 + 4 * W) begin
            k      = 3 - (h - X0) / W;
            e.addr = 17'((v - Y0) * W + (h - X0) % W);
            e.num  = m_dig[4*k +: 4];
            e.en   = (k == 0) || ((m_dig >> (4 * k)) != 16'd0);
        end
        return e;
    endfunction

    task automatic tick(input int h, input int v, input bit r, input bit ld, input int s);
        @(negedge clk_25m);
        h_cnt      = 10'(h);
        v_cnt      = 10'(v);
        rst        = r;
        score_load = ld;
        score      = 14'(s);
        scan_q.push_back(model(h, v, r));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic scan(input int v_lo, input int v_hi, input int h_lo, input int h_hi);
        for (int v = v_lo; v <= v_hi; v++)
            for (int h = h_lo; h <= h_hi; h++)
                tick(h, v, 1'b0, 1'b0, 0);
    endtask

    task automatic wait_conv();
        int budget = 0;
        while (conv_q.size() != 0 && budget < 200) begin
            idle(1);
            budget++;
        end
        check("conv_drained", conv_q.size(), 0);
        idle(1);
        check("busy_idle", busy, 1'b0);
    endtask

    // Pixel monitor: addr/num one cycle after the stimulus, digit_en one cycle later still.
    exp_t mon_cur;
    exp_t mon_prev = '0;
    initial begin
        forever begin
            @(posedge clk_25m);
            #1;
            if (scan_q.size() != 0) begin
                mon_cur = scan_q.pop_front();
                check("addr", addr, mon_cur.addr);
                check("num", num, mon_cur.num);
                check("digit_en", digit_en, mon_cur.rst ? 1'b0 : mon_prev.en);
                mon_prev = mon_cur;
                if (mon_cur.rst) mon_prev.en = 1'b0;
            end
        end
    end

    // Conversion monitor: busy run length, digits held until commit, then all four at once.
    int          run_len = 0;
    bit          await_commit = 1'b0;
    logic [15:0] prev_dig = '0;
    logic [15:0] exp_dig;
    initial begin
        forever begin
            @(posedge clk_25m);
            #1;
            if (rst) begin
                check("busy_in_reset", busy, 1'b0);
                check("digits_in_reset", dut.digits_q, 16'h0000);
                run_len      = 0;
                await_commit = 1'b0;
                prev_dig     = '0;
                conv_q.delete();
            end else begin
                if (await_commit) begin
                    if (conv_q.size() == 0) begin
                        check("unexpected_commit", dut.digits_q, prev_dig);
                    end else begin
                        exp_dig = conv_q.pop_front();
                        check("commit_digits", dut.digits_q, exp_dig);
                        prev_dig = exp_dig;
                    end
                    await_commit = 1'b0;
                end
                if (busy) begin
                    run_len++;
                end else if (run_len > 0) begin
                    check("busy_len", run_len, 14);
                    check("digits_held", dut.digits_q, prev_dig);
                    await_commit = 1'b1;
                    run_len      = 0;
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        score      = '0;
        score_load = 1'b0;
        h_cnt      = '0;
        v_cnt      = '0;

        // Reset with a simultaneous load: the load must be ignored.
        for (int i = 0; i < 3; i++) tick(0, 0, 1'b1, 1'b1, 55);
        idle(20);
        check("no_conv_after_rst_load", busy, 1'b0);

        // Score 0: only the rightmost digit drawn, showing 0.
        tick(0, 0, 1'b0, 1'b1, 0);
        conv_q.push_back(16'h0000);
        wait_conv();
        m_dig = 16'h0000;
        scan(Y0, Y0, X0 - 2, X0 + 4 * W + 1);

        // Score 1234; the pixel at (X0+W+5, Y0+2) gives num 2, addr 165.
        tick(0, 0, 1'b0, 1'b1, 1234);
        conv_q.push_back(16'h1234);
        wait_conv();
        m_dig = 16'h1234;
        scan(Y0 - 1, Y0 + 2, X0 + W + 3, X0 + W + 6);

        // Whole digit strip plus a border of outside pixels.
        scan(Y0 - 2, Y0 + H + 1, X0 - 3, X0 + 4 * W + 2);

        // Saturation at 9999.
        tick(0, 0, 1'b0, 1'b1, 12000);
        conv_q.push_back(16'h9999);
        wait_conv();
        m_dig = 16'h9999;
        scan(Y0, Y0 + 1, X0 - 1, X0 + 4 * W);

        // Score 7: windows 3..1 blanked, window 0 drawn.
        tick(0, 0, 1'b0, 1'b1, 7);
        conv_q.push_back(16'h0007);
        wait_conv();
        m_dig = 16'h0007;
        scan(Y0, Y0, X0 - 2, X0 + 4 * W + 1);

        // Score 500: only the leading zero blanked; inner zeros drawn.
        tick(0, 0, 1'b0, 1'b1, 500);
        conv_q.push_back(16'h0500);
        wait_conv();
        m_dig = 16'h0500;
        scan(Y0, Y0, X0 - 2, X0 + 4 * W + 1);

        // Back-to-back loads while busy: 42 is overwritten by 99 in the pending slot.
        tick(0, 0, 1'b0, 1'b1, 500);
        idle(4);
        tick(0, 0, 1'b0, 1'b1, 42);
        idle(3);
        tick(0, 0, 1'b0, 1'b1, 99);
        conv_q.push_back(16'h0500);
        conv_q.push_back(16'h0099);
        wait_conv();
        m_dig = 16'h0099;
        scan(Y0, Y0, X0 - 2, X0 + 4 * W + 1);

        // Reset in the middle of converting 8888 while pointing inside window 0.
        tick(X0 + 3 * W + 1, Y0, 1'b0, 1'b1, 8888);
        for (int i = 0; i < 5; i++) tick(X0 + 3 * W + 1, Y0, 1'b0, 1'b0, 0);
        check("busy_before_rst", busy, 1'b1);
        m_dig = 16'h0000;
        tick(X0 + 3 * W + 1, Y0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) tick(X0 + 3 * W + 1, Y0, 1'b0, 1'b0, 0);
        idle(20);
        check("busy_after_rst", busy, 1'b0);
        check("digits_after_rst", dut.digits_q, 16'h0000);

        idle(3);
        @(posedge clk_25m);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
